// File: rtl/axi_ad6676_pack_pkg.sv
// Shared definitions for the AD6676 DMA packer: data widths and the
// channel-enable mode encoding.
package axi_ad6676_pack_pkg;

    localparam int unsigned SAMPLE_WIDTH  = 16;
    localparam int unsigned CHANNEL_WIDTH = 32;
    localparam int unsigned DMA_WIDTH     = 64;

    // Mode is {adc_enable_1, adc_enable_0}.
    typedef enum logic [1:0] {
        MODE_NONE = 2'b00,
        MODE_CH0  = 2'b01,
        MODE_CH1  = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

endpackage

// File: rtl/axi_ad6676_pack_fifo.sv
// Synchronous show-ahead FIFO toward the DMA. The head beat is held in a
// register (rd_data), so rd_valid/rd_data follow a write by one cycle.
// A write while full is dropped unless a read happens in the same cycle;
// drop is a combinational strobe for that case.
module axi_ad6676_pack_fifo
    import axi_ad6676_pack_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DMA_WIDTH-1:0]  wr_data,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [DMA_WIDTH-1:0]  rd_data,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  drop
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DMA_WIDTH-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr_n;
    logic [DEPTH_LOG2:0]   level_n;
    logic [DMA_WIDTH-1:0]  head_n;
    logic                  full;
    logic                  rd;
    logic                  wr_ok;

    // Accept/drop decision, next pointers/level and the next head beat.
    // The next head bypasses the array when it is the slot written this cycle.
    always_comb begin
        full     = (level == FULL_LEVEL);
        rd       = rd_valid & rd_ready;
        wr_ok    = wr_en & (~full | rd);
        drop     = wr_en & full & ~rd;
        rd_ptr_n = rd_ptr + {{(DEPTH_LOG2-1){1'b0}}, rd};
        level_n  = level + {{DEPTH_LOG2{1'b0}}, wr_ok} - {{DEPTH_LOG2{1'b0}}, rd};
        head_n   = (wr_ok && (rd_ptr_n == wr_ptr)) ? wr_data : mem[rd_ptr_n];
    end

    // Storage array; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and the registered show-ahead head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
            end
            rd_ptr   <= rd_ptr_n;
            level    <= level_n;
            rd_valid <= (level_n != '0);
            if (level_n != '0) begin
                rd_data <= head_n;
            end
        end
    end

endmodule

// File: rtl/axi_ad6676_pack.sv
// AD6676 ADC-to-DMA packer: packs enabled channel words into 64-bit beats,
// buffers them in a show-ahead FIFO and flags dropped beats on adc_dovf.
// Optional build macro AXI_AD6676_PACK_DROP_CNT_EN adds a saturating
// drop counter (drop_count) with a synchronous clear (drop_count_clr).
module axi_ad6676_pack
    import axi_ad6676_pack_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH_LOG2 = 4
) (
    input  logic                       adc_clk,
    input  logic                       adc_resetn,
    input  logic                       adc_valid_0,
    input  logic                       adc_enable_0,
    input  logic [CHANNEL_WIDTH-1:0]   adc_data_0,
    input  logic                       adc_valid_1,
    input  logic                       adc_enable_1,
    input  logic [CHANNEL_WIDTH-1:0]   adc_data_1,
    output logic                       adc_dovf,
    output logic                       dma_valid,
    output logic [DMA_WIDTH-1:0]       dma_data,
    input  logic                       dma_ready,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
`ifdef AXI_AD6676_PACK_DROP_CNT_EN
    ,
    input  logic                       drop_count_clr,
    output logic [15:0]                drop_count
`endif
);

    mode_t                     mode;
    mode_t                     mode_in;
    logic                      beat;
    logic                      phase;
    logic                      phase_eff;
    logic [CHANNEL_WIDTH-1:0]  single_word;
    logic [CHANNEL_WIDTH-1:0]  half_word;
    logic [DMA_WIDTH-1:0]      pack_reg;
    logic                      pack_vld;
    logic                      fifo_drop;

    // Decode the live mode; a mode change restarts pairing from phase 0.
    always_comb begin
        mode_in     = mode_t'({adc_enable_1, adc_enable_0});
        beat        = (adc_valid_0 & adc_enable_0) | (adc_valid_1 & adc_enable_1);
        phase_eff   = (mode_in == mode) ? phase : 1'b0;
        single_word = (mode_in == MODE_CH1) ? adc_data_1 : adc_data_0;
    end

    // Mode register and packing; the beat in a mode-change cycle packs
    // under the new mode and any pending half word is abandoned.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            mode      <= MODE_NONE;
            phase     <= 1'b0;
            pack_vld  <= 1'b0;
            pack_reg  <= '0;
            half_word <= '0;
        end else begin
            mode     <= mode_in;
            pack_vld <= 1'b0;
            phase    <= 1'b0;
            case (mode_in)
                MODE_BOTH: begin
                    if (beat) begin
                        pack_reg <= {adc_data_1[CHANNEL_WIDTH-1:SAMPLE_WIDTH],
                                     adc_data_0[CHANNEL_WIDTH-1:SAMPLE_WIDTH],
                                     adc_data_1[SAMPLE_WIDTH-1:0],
                                     adc_data_0[SAMPLE_WIDTH-1:0]};
                        pack_vld <= 1'b1;
                    end
                end
                MODE_CH0, MODE_CH1: begin
                    if (beat) begin
                        if (!phase_eff) begin
                            half_word <= single_word;
                            phase     <= 1'b1;
                        end else begin
                            pack_reg <= {single_word, half_word};
                            pack_vld <= 1'b1;
                        end
                    end else begin
                        phase <= phase_eff;
                    end
                end
                default: ;
            endcase
        end
    end

    axi_ad6676_pack_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) i_fifo (
        .clk      (adc_clk),
        .rst_n    (adc_resetn),
        .wr_en    (pack_vld),
        .wr_data  (pack_reg),
        .rd_ready (dma_ready),
        .rd_valid (dma_valid),
        .rd_data  (dma_data),
        .level    (fifo_level),
        .drop     (fifo_drop)
    );

    // One-cycle overflow pulse per dropped beat.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            adc_dovf <= 1'b0;
        end else begin
            adc_dovf <= fifo_drop;
        end
    end

`ifdef AXI_AD6676_PACK_DROP_CNT_EN
    // Saturating drop counter; clear takes priority over a same-cycle drop.
    always_ff @(posedge adc_clk or negedge adc_resetn) begin
        if (!adc_resetn) begin
            drop_count <= '0;
        end else if (drop_count_clr) begin
            drop_count <= '0;
        end else if (fifo_drop && (drop_count != '1)) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`else
    // No drop counter in this build; drops are reported on adc_dovf only.
`endif

endmodule
